// File: rtl/wb_cmd_master.sv
// wb_cmd_master: valid/ready command stream to single classic Wishbone transfers with timeout abort
module wb_cmd_master #(
  parameter int AW      = 8,
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [7:0]    err_cnt,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_wdata,
  input  logic [DW-1:0] wb_rdata,
  output logic          wb_we,
  output logic          wb_cyc,
  input  logic          wb_ack
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  state_t        state_q, state_d;
  logic          wb_cyc_q, wb_cyc_d;
  logic          wb_we_q, wb_we_d;
  logic [AW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_wdata_q, wb_wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic [15:0]   cnt_q, cnt_d;
  // State and output registers; reset drops wb_cyc without waiting for a clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wb_cyc_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_wdata_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_cnt_q   <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      wb_cyc_q    <= wb_cyc_d;
      wb_we_q     <= wb_we_d;
      wb_addr_q   <= wb_addr_d;
      wb_wdata_q  <= wb_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_cnt_q   <= err_cnt_d;
      cnt_q       <= cnt_d;
    end
  end
  // Transfer sequencing: launch, wait for ack or timeout (ack wins a tie), hold response
  always_comb begin
    state_d     = state_q;
    wb_cyc_d    = wb_cyc_q;
    wb_we_d     = wb_we_q;
    wb_addr_d   = wb_addr_q;
    wb_wdata_d  = wb_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_cnt_d   = err_cnt_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d    = BUS;
        wb_cyc_d   = 1'b1;
        wb_we_d    = cmd_we;
        wb_addr_d  = cmd_addr;
        wb_wdata_d = cmd_wdata;
        cnt_d      = '0;
      end
      BUS: if (wb_ack) begin
        state_d     = RESP;
        wb_cyc_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = wb_we_q ? '0 : wb_rdata;
        rsp_err_d   = 1'b0;
      end else if (cnt_q == TO_LAST) begin
        state_d     = RESP;
        wb_cyc_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b1;
        err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      RESP: if (rsp_ready) begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  assign cmd_ready = (state_q == IDLE);
  assign wb_cyc    = wb_cyc_q;
  assign wb_we     = wb_we_q;
  assign wb_addr   = wb_addr_q;
  assign wb_wdata  = wb_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: table, random and corner-case checks of wb_cmd_master against a transfer-level model
module tb_wb_cmd_master;
  localparam int TO = 64;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  err_cnt, wb_addr;
  logic [31:0] wb_wdata, wb_rdata;
  logic        wb_we, wb_cyc, wb_ack;
  logic        ack_r, stray = 1'b0;
  int          slave_lat = 1, scnt;
  int          total = 0, bad = 0, exp_errcnt = 0;

  wb_cmd_master #(.AW(8), .DW(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .err_cnt(err_cnt),
    .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
    .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sdata(input logic [7:0] a);
    return (a == 8'h07) ? 32'h1234_5678 : {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // Slave: acks slave_lat edges after seeing cyc (0 = never), one-cycle ack pulse
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= 1'b0;
      scnt  <= 0;
    end else if (!wb_cyc || ack_r) begin
      ack_r <= 1'b0;
      scnt  <= 0;
    end else if (slave_lat != 0 && scnt + 1 >= slave_lat) ack_r <= 1'b1;
    else scnt <= scnt + 1;
  end
  assign wb_ack   = ack_r | stray;
  assign wb_rdata = ack_r ? sdata(wb_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Transfer-level model: ack arrives on bus cycle lat+1; it counts only if within TO cycles
  task automatic model(input logic we, input logic [7:0] addr, input int lat,
                       output logic [31:0] erd, output logic eerr, output int ecyc);
    logic ok;
    ok   = (lat != 0) && (lat + 1 <= TO);
    ecyc = ok ? lat + 1 : TO;
    eerr = !ok;
    erd  = (ok && !we) ? sdata(addr) : 32'h0;
  endtask

  // One complete transfer starting and ending at a negedge; cmd_valid stays high with junk after acceptance
  task automatic txn(input string nm, input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                     input int lat, input int hold, input logic [31:0] erd, input logic eerr, input int ecyc);
    int n, cyc;
    logic bus_ok, rsp_ok;
    slave_lat = lat;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    chk({nm, ".accept"}, 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_we = ~we; cmd_addr = ~addr; cmd_wdata = ~wdata;
    cyc = 0; n = 0; bus_ok = 1'b1;
    while (!rsp_valid && n < TO + 10) begin
      if (wb_cyc) cyc++;
      if (wb_we !== we || wb_addr !== addr || wb_wdata !== wdata || cmd_ready !== 1'b0) bus_ok = 1'b0;
      @(negedge clk); n++;
    end
    if (eerr) exp_errcnt = (exp_errcnt == 255) ? 255 : exp_errcnt + 1;
    chk({nm, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({nm, ".latency"}, 32'(n), 32'(ecyc));
    chk({nm, ".cyc_len"}, 32'(cyc), 32'(ecyc));
    chk({nm, ".bus_stable"}, 32'(bus_ok), 32'd1);
    chk({nm, ".cyc_idle"}, 32'(wb_cyc), 32'd0);
    chk({nm, ".rdata"}, rsp_rdata, erd);
    chk({nm, ".err"}, 32'(rsp_err), 32'(eerr));
    chk({nm, ".err_cnt"}, 32'(err_cnt), 32'(exp_errcnt));
    rsp_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_rdata !== erd || rsp_err !== eerr || cmd_ready || wb_cyc) rsp_ok = 1'b0;
    end
    if (hold > 0) chk({nm, ".backpressure"}, 32'(rsp_ok), 32'd1);
    rsp_ready = 1'b1; cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, ".rsp_done"}, 32'(rsp_valid), 32'd0);
    chk({nm, ".ready_again"}, 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    string       nm;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    int          hold;
    logic [31:0] erd;
    logic        eerr;
    int          ecyc;
  } vec_t;

  initial begin
    vec_t vt[8];
    logic [31:0] erd;
    logic eerr;
    int ecyc, lat;
    logic we;
    logic [7:0] a;
    vt[0] = '{"read7",     1'b0, 8'h07, 32'h0,         1,  0,  32'h1234_5678, 1'b0, 2};
    vt[1] = '{"write8",    1'b1, 8'h08, 32'h8000_0800, 1,  0,  32'h0,         1'b0, 2};
    vt[2] = '{"bp_write",  1'b1, 8'h10, 32'hCAFE_F00D, 3,  10, 32'h0,         1'b0, 4};
    vt[3] = '{"last_ack",  1'b0, 8'h07, 32'h0,         63, 0,  32'h1234_5678, 1'b0, 64};
    vt[4] = '{"noslave",   1'b0, 8'h22, 32'h0,         0,  0,  32'h0,         1'b1, 64};
    vt[5] = '{"late_ack",  1'b0, 8'h22, 32'h0,         64, 0,  32'h0,         1'b1, 64};
    vt[6] = '{"read3c",    1'b0, 8'h3C, 32'h0,         2,  3,  32'h3CC3_66C3, 1'b0, 3};
    vt[7] = '{"wr_noslv",  1'b1, 8'h55, 32'h1111_2222, 0,  2,  32'h0,         1'b1, 64};
    #3;
    chk("rst.cyc", 32'(wb_cyc), 32'd0);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.err_cnt", 32'(err_cnt), 32'd0);
    chk("rst.addr", 32'(wb_addr), 32'd0);
    chk("rst.wdata", wb_wdata, 32'd0);
    chk("rst.rdata", rsp_rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    foreach (vt[i]) txn(vt[i].nm, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].lat, vt[i].hold,
                        vt[i].erd, vt[i].eerr, vt[i].ecyc);
    // stray ack in IDLE must not produce a response
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) @(negedge clk);
    chk("stray.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stray.cyc", 32'(wb_cyc), 32'd0);
    for (int k = 0; k < 40; k++) begin
      we  = 1'($urandom);
      a   = 8'($urandom);
      lat = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 70) : $urandom_range(1, 5);
      model(we, a, lat, erd, eerr, ecyc);
      txn("rand", we, a, $urandom, lat, $urandom_range(0, 3), erd, eerr, ecyc);
    end
    // reset asserted in the middle of a bus cycle
    slave_lat = 0;
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 8'h07;
    for (int n = 0; n < 200 && !cmd_ready; n++) @(negedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("arst.before", 32'(wb_cyc), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.cyc", 32'(wb_cyc), 32'd0);
    chk("arst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("arst.err_cnt", 32'(err_cnt), 32'd0);
    exp_errcnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    txn("post_rst", 1'b0, 8'h07, 32'h0, 1, 0, 32'h1234_5678, 1'b0, 2);
    // error counter saturation
    for (int k = 0; k < 300; k++) txn("sat", 1'b0, 8'($urandom), 32'h0, 0, 0, 32'h0, 1'b1, TO);
    chk("sat.err_cnt", 32'(err_cnt), 32'hFF);
    txn("sat_ok", 1'b1, 8'h08, 32'h8000_0800, 1, 0, 32'h0, 1'b0, 2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
